// File: rtl/hilo_muldiv_sequencer.sv
// Iterative multiply/divide engine for the Execute stage, feeding the HiLo register file.
// Handles MULT/MULTU/DIV/DIVU/MADD/MSUB one bit per cycle, then sign-fixes and accumulates.
// Build option: define MULDIV_EARLY_OUT_EN to let multiplies stop iterating once the
// remaining multiplier-magnitude bits are all zero (divide latency is unaffected).
module hilo_muldiv_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic [2:0]            Op,
    input  logic [DATA_WIDTH-1:0] OpA,
    input  logic [DATA_WIDTH-1:0] OpB,
    input  logic [DATA_WIDTH-1:0] HiIn,
    input  logic [DATA_WIDTH-1:0] LoIn,
    input  logic                  Flush,
    output logic                  Busy,
    output logic                  Stall,
    output logic                  Done,
    output logic                  HiWrite,
    output logic                  LoWrite,
    output logic [DATA_WIDTH-1:0] HiOut,
    output logic [DATA_WIDTH-1:0] LoOut
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned PW = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {StIdle, StCalc, StFix, StAcc, StDone} state_e;

    function automatic logic op_div(input logic [2:0] o);
        return (o == 3'd2) || (o == 3'd3);
    endfunction

    function automatic logic op_signed(input logic [2:0] o);
        return (o != 3'd1) && (o != 3'd3);
    endfunction

    function automatic logic op_acc(input logic [2:0] o);
        return (o == 3'd4) || (o == 3'd5);
    endfunction

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]   prod_q, prod_d;     // mul: running product; div: {remainder, dividend/quotient}
    logic [PW-1:0]   aux_q, aux_d;       // mul: multiplicand shifted left; div: divisor in low half
    logic [DW-1:0]   mq_q, mq_d;         // multiplier bits not yet consumed
    logic [PW-1:0]   acc_q, acc_d;       // {HiIn, LoIn} captured at accept
    logic [DW-1:0]   opa_q, opa_d;       // raw dividend, returned as Hi on divide-by-zero
    logic            neg_q, neg_d;       // operand signs differ (product / quotient negated)
    logic            neg_rem_q, neg_rem_d;
    logic            divz_q, divz_d;
    logic [DW-1:0]   hi_out_q, hi_out_d;
    logic [DW-1:0]   lo_out_q, lo_out_d;

    logic            start_ok;
    logic            in_signed;
    logic [DW-1:0]   mag_a, mag_b;
    logic [PW-1:0]   mul_sum;
    logic [DW-1:0]   mq_next;
    logic [DW:0]     rem_sh;
    logic            sub_ok;
    logic [DW-1:0]   rem_sub;
    logic [PW-1:0]   div_next;
    logic [DW-1:0]   fix_rem, fix_quo;
    logic [PW-1:0]   fix_res, acc_res;
    logic            early_exit;

    assign start_ok  = Start && (Op <= 3'd5) && !Flush;
    assign in_signed = op_signed(Op);
    assign mag_a     = (in_signed && OpA[DW-1]) ? -OpA : OpA;
    assign mag_b     = (in_signed && OpB[DW-1]) ? -OpB : OpB;

    // Shift-add multiply step
    assign mul_sum = prod_q + (mq_q[0] ? aux_q : '0);
    assign mq_next = mq_q >> 1;

    // Restoring divide step: shift {rem, quo} left and try to subtract the divisor
    assign rem_sh   = {prod_q[PW-1:DW], prod_q[DW-1]};
    assign sub_ok   = rem_sh >= {1'b0, aux_q[DW-1:0]};
    assign rem_sub  = rem_sh[DW-1:0] - aux_q[DW-1:0];
    assign div_next = sub_ok ? {rem_sub, prod_q[DW-2:0], 1'b1}
                             : {rem_sh[DW-1:0], prod_q[DW-2:0], 1'b0};

    // Sign correction; divide-by-zero bypasses it and reports the raw dividend
    assign fix_rem = neg_rem_q ? -prod_q[PW-1:DW] : prod_q[PW-1:DW];
    assign fix_quo = neg_q ? -prod_q[DW-1:0] : prod_q[DW-1:0];
    assign fix_res = op_div(op_q) ? (divz_q ? {opa_q, {DW{1'b1}}} : {fix_rem, fix_quo})
                                  : (neg_q ? -prod_q : prod_q);
    assign acc_res = (op_q == 3'd5) ? (acc_q - prod_q) : (acc_q + prod_q);

`ifdef MULDIV_EARLY_OUT_EN
    assign early_exit = !op_div(op_q) && (mq_next == '0);
`else
    assign early_exit = 1'b0;
`endif

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        aux_d     = aux_q;
        mq_d      = mq_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        divz_d    = divz_q;
        hi_out_d  = hi_out_q;
        lo_out_d  = lo_out_q;

        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    op_d      = Op;
                    cnt_d     = CNT_W'(DW);
                    acc_d     = {HiIn, LoIn};
                    opa_d     = OpA;
                    neg_d     = in_signed && (OpA[DW-1] ^ OpB[DW-1]);
                    neg_rem_d = in_signed && OpA[DW-1];
                    divz_d    = (OpB == '0);
                    mq_d      = mag_b;
                    if (op_div(Op)) begin
                        prod_d = {{DW{1'b0}}, mag_a};
                        aux_d  = {{DW{1'b0}}, mag_b};
                    end else begin
                        prod_d = '0;
                        aux_d  = {{DW{1'b0}}, mag_a};
                    end
                    state_d = StCalc;
                end
            end
            StCalc: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (op_div(op_q)) begin
                    prod_d = div_next;
                end else begin
                    prod_d = mul_sum;
                    aux_d  = aux_q << 1;
                    mq_d   = mq_next;
                end
                if ((cnt_q == CNT_W'(1)) || early_exit) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (op_acc(op_q)) begin
                    prod_d  = fix_res;
                    state_d = StAcc;
                end else begin
                    {hi_out_d, lo_out_d} = fix_res;
                    state_d = StDone;
                end
            end
            StAcc: begin
                {hi_out_d, lo_out_d} = acc_res;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Squash: drop the operation and keep the previously written result
        if (Flush) begin
            state_d  = StIdle;
            hi_out_d = hi_out_q;
            lo_out_d = lo_out_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q   <= StIdle;
            op_q      <= '0;
            cnt_q     <= '0;
            prod_q    <= '0;
            aux_q     <= '0;
            mq_q      <= '0;
            acc_q     <= '0;
            opa_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
            hi_out_q  <= '0;
            lo_out_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            aux_q     <= aux_d;
            mq_q      <= mq_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            divz_q    <= divz_d;
            hi_out_q  <= hi_out_d;
            lo_out_q  <= lo_out_d;
        end
    end

    assign Busy    = (state_q != StIdle);
    assign Done    = (state_q == StDone);
    assign HiWrite = Done;
    assign LoWrite = Done;
    assign Stall   = Busy || start_ok;
    assign HiOut   = hi_out_q;
    assign LoOut   = lo_out_q;

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Self-checking bench for hilo_muldiv_sequencer: directed vectors, randomized ops against
// an arithmetic reference model, flush/reset aborts, ignored starts and back-to-back issue.
module tb_hilo_muldiv_sequencer;

    localparam int DW = 32;

    logic          Clk = 1'b0;
    logic          Rst, Start, Flush;
    logic [2:0]    Op;
    logic [DW-1:0] OpA, OpB, HiIn, LoIn;
    logic          Busy, Stall, Done, HiWrite, LoWrite;
    logic [DW-1:0] HiOut, LoOut;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] exp_hi = '0;  // last result the DUT should be holding
    logic [DW-1:0] exp_lo = '0;

    always #5 Clk = ~Clk;

    hilo_muldiv_sequencer dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
        .HiIn(HiIn), .LoIn(LoIn), .Flush(Flush), .Busy(Busy), .Stall(Stall),
        .Done(Done), .HiWrite(HiWrite), .LoWrite(LoWrite), .HiOut(HiOut), .LoOut(LoOut)
    );

    // Reference result {Hi, Lo} from plain 64-bit arithmetic
    function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a, b,
                                            input logic [31:0] hi, lo);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     acc, p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        acc = {hi, lo};
        p   = '0;
        case (op)
            3'd0: p = sa * sb;
            3'd1: p = ua * ub;
            3'd2: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {32'(r), 32'(q)};
                end
            end
            3'd3: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else p = {32'(ua % ub), 32'(ua / ub)};
            end
            3'd4: p = acc + 64'(sa * sb);
            3'd5: p = acc - 64'(sa * sb);
            default: p = '0;
        endcase
        return p;
    endfunction

    // Reference Done cycle (accept cycle = 0)
    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] b);
        int lat;
        lat = DW + 2;
`ifdef MULDIV_EARLY_OUT_EN
        if (op != 3'd2 && op != 3'd3) begin
            logic [31:0] mag;
            int k;
            mag = (op != 3'd1 && b[31]) ? -b : b;
            k = 0;
            for (int i = 0; i < 32; i++) if (mag[i]) k = i + 1;
            lat = ((k > 1) ? k : 1) + 2;
        end
`endif
        if (op == 3'd4 || op == 3'd5) lat++;
        return lat;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    // Issue one op from an idle DUT and follow it to Done (bounded); no checking here
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, b, hi, lo,
                         output int lat, output logic [31:0] rhi, rlo,
                         output int busy_bad, output logic wr);
        Start = 1'b1; Op = op; OpA = a; OpB = b; HiIn = hi; LoIn = lo;
        @(posedge Clk); #1;
        Start = 1'b0;
        OpA = $urandom(); OpB = $urandom(); HiIn = $urandom(); LoIn = $urandom();
        lat = -1; busy_bad = 0; rhi = '0; rlo = '0; wr = 1'b0;
        for (int c = 1; c <= 80 && lat < 0; c++) begin
            @(negedge Clk);
            if (Busy !== 1'b1) busy_bad++;
            if (Done === 1'b1) begin
                lat = c; rhi = HiOut; rlo = LoOut; wr = HiWrite & LoWrite;
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_reset();
        Rst = 1'b0; Start = 1'b0; Flush = 1'b0; Op = 3'd0;
        OpA = '0; OpB = '0; HiIn = '0; LoIn = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", Done); end
        n_cmp++; if ({HiWrite, LoWrite} !== 2'b00) begin n_bad++; $display("FAIL reset_write: got %b%b expected 00", HiWrite, LoWrite); end
        n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", Stall); end
        n_cmp++; if ({HiOut, LoOut} !== 64'd0) begin n_bad++; $display("FAIL reset_out: got %h_%h expected 0", HiOut, LoOut); end
        @(posedge Clk); #1;
        Rst = 1'b1;
    endtask

    logic [2:0]  v_op [8] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd2, 3'd2};
    logic [31:0] v_a  [8] = '{32'd7, 32'hFFFF_FFF9, 32'd9, 32'd1, 32'd1, 32'd5, 32'h8000_0000, 32'hFFFF_FFF9};
    logic [31:0] v_b  [8] = '{32'hFFFF_FFFD, 32'd2, 32'd0, 32'd1, 32'd1, 32'd3, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] v_hi [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9, 32'd1, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFF9};
    logic [31:0] v_lo [8] = '{32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE, 32'd15,
                              32'h8000_0000, 32'hFFFF_FFFF};

    task automatic test_directed();
        int lat, bb; logic [31:0] rh, rl; logic wr;
        for (int i = 0; i < 8; i++) begin
            do_op(v_op[i], v_a[i], v_b[i], 32'd0, 32'hFFFF_FFFF, lat, rh, rl, bb, wr);
            n_cmp++; if ({rh, rl} !== {v_hi[i], v_lo[i]}) begin n_bad++;
                $display("FAIL dir[%0d] result: got %h_%h expected %h_%h", i, rh, rl, v_hi[i], v_lo[i]); end
            n_cmp++; if (lat !== ref_lat(v_op[i], v_b[i])) begin n_bad++;
                $display("FAIL dir[%0d] latency: got %0d expected %0d", i, lat, ref_lat(v_op[i], v_b[i])); end
            n_cmp++; if (bb !== 0 || wr !== 1'b1) begin n_bad++;
                $display("FAIL dir[%0d] busy/write: busy gaps %0d write %b expected 0 and 1", i, bb, wr); end
            exp_hi = v_hi[i]; exp_lo = v_lo[i];
            @(negedge Clk);
            n_cmp++; if (Busy !== 1'b0 || Done !== 1'b0 || {HiOut, LoOut} !== {exp_hi, exp_lo}) begin n_bad++;
                $display("FAIL dir[%0d] after_done: busy %b done %b out %h_%h expected 0 0 %h_%h",
                         i, Busy, Done, HiOut, LoOut, exp_hi, exp_lo); end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_random();
        int lat, bb; logic [31:0] rh, rl, a, b, h, l; logic wr; logic [2:0] op; logic [63:0] e;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 5)); a = pick(); b = pick(); h = $urandom(); l = $urandom();
            e = ref_res(op, a, b, h, l);
            do_op(op, a, b, h, l, lat, rh, rl, bb, wr);
            n_cmp++; if ({rh, rl} !== e) begin n_bad++;
                $display("FAIL rand[%0d] op%0d a=%h b=%h result: got %h_%h expected %h", i, op, a, b, rh, rl, e); end
            n_cmp++; if (lat !== ref_lat(op, b) || bb !== 0) begin n_bad++;
                $display("FAIL rand[%0d] op%0d timing: lat %0d busy gaps %0d expected %0d and 0",
                         i, op, lat, bb, ref_lat(op, b)); end
            {exp_hi, exp_lo} = e;
        end
    endtask

    task automatic test_flush();
        int lat, bb, dn; logic [31:0] rh, rl; logic wr; logic [63:0] e;
        Start = 1'b1; Op = 3'd1; OpA = 32'h1234_5678; OpB = 32'h8765_4321;
        @(posedge Clk); #1;
        Start = 1'b0;
        dn = 0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 10) Flush = 1'b1;
            @(negedge Clk);
            if (Done !== 1'b0 || HiWrite !== 1'b0) dn++;
            @(posedge Clk); #1;
        end
        Flush = 1'b0;
        @(negedge Clk);
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy: got %b expected 0", Busy); end
        n_cmp++; if (dn !== 0) begin n_bad++; $display("FAIL flush_nodone: got %0d strobes expected 0", dn); end
        n_cmp++; if ({HiOut, LoOut} !== {exp_hi, exp_lo}) begin n_bad++;
            $display("FAIL flush_hold: got %h_%h expected %h_%h", HiOut, LoOut, exp_hi, exp_lo); end
        e = ref_res(3'd0, 32'hFFFF_0003, 32'd12345, 0, 0);
        do_op(3'd0, 32'hFFFF_0003, 32'd12345, 32'd0, 32'd0, lat, rh, rl, bb, wr);
        n_cmp++; if ({rh, rl} !== e || lat !== ref_lat(3'd0, 32'd12345)) begin n_bad++;
            $display("FAIL flush_restart: got %h_%h lat %0d expected %h lat %0d", rh, rl, lat, e,
                     ref_lat(3'd0, 32'd12345)); end
        {exp_hi, exp_lo} = e;
    endtask

    task automatic test_ignored();
        int dn, first; logic [31:0] rh, rl, a, b; logic [63:0] e;
        a = $urandom(); b = $urandom() | 32'h1;
        e = ref_res(3'd3, a, b, 0, 0);
        Start = 1'b1; Op = 3'd3; OpA = a; OpB = b;
        @(posedge Clk); #1;
        Start = 1'b0;
        dn = 0; first = -1; rh = '0; rl = '0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) begin Start = 1'b1; Op = 3'd0; OpA = ~a; OpB = 32'd3; end
            if (c == 6) Start = 1'b0;
            @(negedge Clk);
            if (c == 5) begin
                n_cmp++; if (Stall !== 1'b1) begin n_bad++; $display("FAIL busy_stall: got %b expected 1", Stall); end
            end
            if (Done === 1'b1) begin dn++; if (first < 0) begin first = c; rh = HiOut; rl = LoOut; end end
            @(posedge Clk); #1;
        end
        n_cmp++; if (dn !== 1 || first !== 34) begin n_bad++;
            $display("FAIL busy_start: got %0d dones first at %0d expected 1 at 34", dn, first); end
        n_cmp++; if ({rh, rl} !== e) begin n_bad++; $display("FAIL busy_result: got %h_%h expected %h", rh, rl, e); end
        {exp_hi, exp_lo} = e;
        Start = 1'b1; Op = 3'd7;
        @(negedge Clk);
        n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL op7_stall: got %b expected 0", Stall); end
        @(posedge Clk); #1;
        Start = 1'b0;
        dn = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            if (Busy !== 1'b0 || Done !== 1'b0) dn++;
            @(posedge Clk); #1;
        end
        n_cmp++; if (dn !== 0) begin n_bad++; $display("FAIL op7_ignored: got %0d busy cycles expected 0", dn); end
    endtask

    task automatic test_back_to_back();
        int lat, bb; logic [31:0] rh, rl, a; logic wr; logic [63:0] e;
        for (int i = 0; i < 3; i++) begin
            a = pick();
            e = ref_res(3'd4, a, 32'hFFFF_FFFE, 32'h0000_0010, 32'h0000_0020);
            do_op(3'd4, a, 32'hFFFF_FFFE, 32'h0000_0010, 32'h0000_0020, lat, rh, rl, bb, wr);
            n_cmp++; if ({rh, rl} !== e || lat !== ref_lat(3'd4, 32'hFFFF_FFFE) || bb !== 0) begin n_bad++;
                $display("FAIL b2b[%0d]: got %h_%h lat %0d gaps %0d expected %h lat %0d gaps 0",
                         i, rh, rl, lat, bb, e, ref_lat(3'd4, 32'hFFFF_FFFE)); end
            {exp_hi, exp_lo} = e;
        end
    endtask

    task automatic test_flush_done();
        int el; logic [31:0] a, b; logic [63:0] e;
        a = $urandom(); b = pick();
        e = ref_res(3'd1, a, b, 0, 0);
        el = ref_lat(3'd1, b);
        Start = 1'b1; Op = 3'd1; OpA = a; OpB = b;
        @(posedge Clk); #1;
        Start = 1'b0;
        for (int c = 1; c < el; c++) begin @(posedge Clk); #1; end
        Flush = 1'b1;
        @(negedge Clk);
        n_cmp++; if (Done !== 1'b1 || HiWrite !== 1'b1 || {HiOut, LoOut} !== e) begin n_bad++;
            $display("FAIL flush_in_done: done %b write %b out %h_%h expected 1 1 %h", Done, HiWrite, HiOut, LoOut, e); end
        @(posedge Clk); #1;
        Flush = 1'b0;
        @(negedge Clk);
        n_cmp++; if (Busy !== 1'b0 || {HiOut, LoOut} !== e) begin n_bad++;
            $display("FAIL flush_after_done: busy %b out %h_%h expected 0 %h", Busy, HiOut, LoOut, e); end
        {exp_hi, exp_lo} = e;
        @(posedge Clk); #1;
        Start = 1'b1; Flush = 1'b1; Op = 3'd0;
        @(negedge Clk);
        n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL flush_vs_start_stall: got %b expected 0", Stall); end
        @(posedge Clk); #1;
        Start = 1'b0; Flush = 1'b0;
        @(negedge Clk);
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL flush_vs_start_busy: got %b expected 0", Busy); end
        @(posedge Clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat, bb; logic [31:0] rh, rl; logic wr; logic [63:0] e;
        Start = 1'b1; Op = 3'd4; OpA = 32'hDEAD_BEEF; OpB = 32'h0000_1111;
        HiIn = 32'h1; LoIn = 32'h2;
        @(posedge Clk); #1;
        Start = 1'b0;
        for (int c = 1; c < 15; c++) begin @(posedge Clk); #1; end
        Rst = 1'b0;
        @(posedge Clk); #1;
        @(negedge Clk);
        n_cmp++; if (Busy !== 1'b0 || Done !== 1'b0 || {HiOut, LoOut} !== 64'd0) begin n_bad++;
            $display("FAIL reset_mid: busy %b done %b out %h_%h expected 0 0 0", Busy, Done, HiOut, LoOut); end
        @(posedge Clk); #1;
        Rst = 1'b1;
        e = ref_res(3'd5, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'd0);
        do_op(3'd5, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'd0, lat, rh, rl, bb, wr);
        n_cmp++; if ({rh, rl} !== e || lat !== ref_lat(3'd5, 32'h7FFF_FFFF)) begin n_bad++;
            $display("FAIL reset_recover: got %h_%h lat %0d expected %h lat %0d", rh, rl, lat, e,
                     ref_lat(3'd5, 32'h7FFF_FFFF)); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_ignored();
        test_back_to_back();
        test_flush_done();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
